// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Round-robin arbiter with bounded burst locking that shares one
//            synchronous RAM port among NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            ram_wr_en,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_din,
  input  logic [DATA_WIDTH-1:0]           ram_dout
);

  localparam int                 c_IDX_W      = $clog2(NUM_REQ);
  localparam logic [7:0]         c_BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [7:0]           r_burst_cnt, w_burst_cnt_nxt;
  logic                 w_gnt;
  logic [c_IDX_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0]   r_rsp_valid;

  function automatic logic [c_IDX_W-1:0] f_inc(input logic [c_IDX_W-1:0] idx);
    return (idx == c_IDX_LAST) ? '0 : idx + c_IDX_W'(1);
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    w_gnt           = 1'b0;
    w_gnt_idx       = '0;
    if (!rst) begin
      case (r_state)
        ST_ARB: begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt && req_valid[c_IDX_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
              w_gnt     = 1'b1;
              w_gnt_idx = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            end
          end
          if (w_gnt) begin
            // A one-access burst limit makes locking meaningless, so lock is ignored.
            if (req_lock[w_gnt_idx] && MAX_BURST > 1) begin
              w_owner_nxt     = w_gnt_idx;
              w_burst_cnt_nxt = 8'd1;
              w_state_nxt     = ST_LOCKED;
            end else begin
              w_ptr_nxt = f_inc(w_gnt_idx);
            end
          end
        end
        ST_LOCKED: begin
          if (req_valid[r_owner]) begin
            w_gnt     = 1'b1;
            w_gnt_idx = r_owner;
            if (req_lock[r_owner] && r_burst_cnt < c_BURST_LAST) begin
              w_burst_cnt_nxt = r_burst_cnt + 8'd1;
            end else begin
              w_ptr_nxt       = f_inc(r_owner);
              w_burst_cnt_nxt = '0;
              w_state_nxt     = ST_ARB;
            end
          end else begin
            // Owner went idle: release without granting anyone this cycle.
            w_ptr_nxt       = f_inc(r_owner);
            w_burst_cnt_nxt = '0;
            w_state_nxt     = ST_ARB;
          end
        end
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    if (w_gnt) begin
      req_ready[w_gnt_idx] = 1'b1;
      ram_wr_en            = req_we[w_gnt_idx];
      ram_addr             = req_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_din              = req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rsp_valid <= req_ready & ~req_we;
    end
  end

  // Masking with rst drops a response whose read was accepted just before reset.
  assign rsp_valid = r_rsp_valid & {NUM_REQ{~rst}};
  assign rsp_data  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter with a RAM model
//            and an abstract grant/response reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int DW = 36;
  localparam int AW = 10;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we    = '0;
  logic [NR-1:0]     req_lock  = '0;
  logic [NR*AW-1:0]  req_addr  = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              ram_wr_en;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout = '0;

  logic [DW-1:0]     ram_mem [1024];
  logic [DW-1:0]     shadow  [1024];

  int checks = 0;
  int errors = 0;

  // Reference model: next scan start, lock owner (-1 = none), accesses used in burst.
  int            m_start = 0;
  int            m_owner = -1;
  int            m_used  = 0;
  logic [NR-1:0] m_rsp_v = '0;
  logic [DW-1:0] m_rsp_d = '0;

  int            log_q[$];
  int            c_rem  [NR];
  int            c_mode [NR];
  logic [AW-1:0] c_addr [NR];

  ram_port_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < NR; i++) if (v[i]) begin r = i; c++; end
    return (c > 1) ? 99 : r;
  endfunction

  task automatic compare_cycle();
    int            g = -1;
    logic [NR-1:0] exp_rdy = '0;
    logic          we_g = 1'b0;
    logic          lk = 1'b0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    if (!rst) begin
      if (m_owner >= 0) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(m_start + k) % NR]) g = (m_start + k) % NR;
      end
    end
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      we_g = req_we[g];
      lk   = req_lock[g];
      a    = req_addr[g*AW +: AW];
      d    = req_wdata[g*DW +: DW];
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("ram_wr_en", ram_wr_en, we_g);
    chk("ram_addr", ram_addr, a);
    chk("ram_din", ram_din, d);
    chk("rsp_valid", rsp_valid, rst ? '0 : m_rsp_v);
    if (!rst && m_rsp_v != '0) chk("rsp_data", rsp_data, m_rsp_d);

    if (rst) begin
      m_start = 0; m_owner = -1; m_used = 0; m_rsp_v = '0;
    end else begin
      m_rsp_v = '0;
      if (g >= 0) begin
        if (we_g) shadow[a] = d;
        else begin
          m_rsp_v[g] = 1'b1;
          m_rsp_d    = shadow[a];
        end
        if (m_owner < 0) begin
          if (lk && MB > 1) begin m_owner = g; m_used = 1; end
          else m_start = (g + 1) % NR;
        end else begin
          m_used++;
          if (!lk || m_used >= MB) begin m_start = (g + 1) % NR; m_owner = -1; end
        end
      end else if (m_owner >= 0) begin
        m_start = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic do_access(input int i, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_lock[i]  = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL access_timeout req%0d actual=no_grant required=grant", i);
    end
    @(posedge clk); #1;
  endtask

  function automatic bit clients_busy();
    for (int i = 0; i < NR; i++) if (c_rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_clients();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (c_rem[i] > 0);
      req_we[i]    = 1'b0;
      req_lock[i]  = (c_mode[i] == 2) ? 1'b1 : (c_mode[i] == 1) ? (c_rem[i] > 1) : 1'b0;
      req_addr[i*AW +: AW] = c_addr[i];
    end
  endtask

  task automatic run_clients(input int budget);
    logic [NR-1:0] acc;
    int n = 0;
    log_q.delete();
    drive_clients();
    while (clients_busy() && n < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      log_q.push_back(oh2idx(req_ready));
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (acc[i]) begin c_rem[i]--; c_addr[i]++; end
      drive_clients();
      n++;
    end
    if (clients_busy()) begin
      checks++; errors++;
      $display("FAIL clients_timeout actual=busy required=done");
    end
    clear_reqs();
  endtask

  task automatic check_seq(input string name, input int exp_q[$], input bit keep_idle);
    int act[$];
    foreach (log_q[k]) if (keep_idle || log_q[k] >= 0) act.push_back(log_q[k]);
    while (act.size() > 0 && act[0] < 0) void'(act.pop_front());
    while (act.size() > 0 && act[act.size()-1] < 0) void'(act.pop_back());
    chk({name, "_len"}, 64'(act.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s[%0d]", name, k), (k < act.size()) ? act[k] : -1, exp_q[k]);
  endtask

  initial begin
    int q[$];
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = DW'(i * 7 + 3);
      shadow[i]  = DW'(i * 7 + 3);
    end
    fork
      forever begin
        @(posedge clk);
        ram_dout <= ram_mem[ram_addr];
        if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
      end
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Reset with every requester asking: nothing may be granted.
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("reset_ready", req_ready, 4'b0000);
    chk("reset_wr_en", ram_wr_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_reqs();
    repeat (10) @(negedge clk);
    chk("idle_rsp_valid", rsp_valid, 4'b0000);
    @(posedge clk); #1;

    // Write then read back through requester 1.
    do_access(1, 1'b1, 1'b0, 10'h005, 36'h123456789);
    do_access(1, 1'b0, 1'b0, 10'h005, 36'h0);
    clear_reqs();
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 4'b0010);
    chk("t2_rsp_data", rsp_data, 36'h123456789);
    @(posedge clk); #1;

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain round robin among four readers.
    for (int i = 0; i < NR; i++) begin c_rem[i] = 2; c_mode[i] = 0; c_addr[i] = AW'(16 * i); end
    run_clients(40);
    q = {0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("t3_order", q, 1'b0);

    // Move the pointer to 2, then a 12-read locked burst from requester 2.
    do_access(1, 1'b0, 1'b0, 10'h030, 36'h0);
    clear_reqs();
    c_rem  = '{1, 0, 12, 1};
    c_mode = '{0, 0, 1, 0};
    c_addr = '{10'h100, 10'h000, 10'h200, 10'h300};
    run_clients(60);
    q = {2, 2, 2, 2, 2, 2, 2, 2, 3, 0, 2, 2, 2, 2};
    check_seq("t4_order", q, 1'b0);

    // Locked owner goes idle after three accesses.
    c_rem  = '{3, 1, 0, 0};
    c_mode = '{2, 0, 0, 0};
    c_addr = '{10'h040, 10'h050, 10'h000, 10'h000};
    run_clients(40);
    q = {0, 0, 0, -1, 1};
    check_seq("t5_order", q, 1'b1);

    // Read accepted right before reset: its response must be dropped.
    do_access(3, 1'b0, 1'b0, 10'h020, 36'h0);
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    chk("t6_rsp_dropped", rsp_valid, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t6_rsp_after_reset", rsp_valid, 4'b0000);
    chk("t6_first_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    clear_reqs();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one synchronous port of the team's dual-port RAM (1-cycle registered read, old-data-on-collision) among NUM_REQ requesters.
- Arbitration is round-robin. Bounded burst locking lets one client issue back-to-back accesses.
- Read data returns to the issuing requester exactly one cycle after acceptance, tagged by a one-hot response valid.
- Sits between client engines and one RAM port; the other RAM port stays free for an independent agent.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 36, RAM word width
- ADDR_WIDTH, 10, RAM address width
- MAX_BURST, 8, max consecutive grants under lock before forced rotation (1..255)

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester access request
- req_we  input  NUM_REQ  1=write, 0=read
- req_lock  input  NUM_REQ  hold grant for next access (burst)
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data, same packing
- req_ready  output  NUM_REQ  one-hot grant; access accepted when valid&ready
- rsp_valid  output  NUM_REQ  one-hot read-data valid
- rsp_data  output  DATA_WIDTH  read data, shared by all requesters
- ram_wr_en  output  1  to RAM port wr_en
- ram_addr  output  ADDR_WIDTH  to RAM port addr
- ram_din  output  DATA_WIDTH  to RAM port din
- ram_dout  input  DATA_WIDTH  from RAM port dout

Behaviour:
- Handshake:
  - req_ready is combinational from req_valid and arbiter state. At most one bit is set, and only on a valid requester.
  - Requester holds valid/we/addr/wdata/lock stable until accepted.
  - Exactly one access per cycle.
- RAM drive (combinational from granted requester):
  - ram_addr, ram_din = granted requester's fields.
  - ram_wr_en = req_we of granted requester.
  - With no grant: ram_wr_en=0, ram_addr/ram_din=0.
- Read latency:
  - Read accepted at edge N gives rsp_valid[i]=1 during cycle N+1 (registered), with rsp_data = ram_dout passed through.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses, full throughput.
- States: ARB, LOCKED.
- ARB:
  - Grant the first valid requester scanning from pointer ptr upward, wrapping modulo NUM_REQ.
  - On acceptance by i with req_lock[i]=0: ptr<=i+1 mod NUM_REQ.
  - On acceptance with req_lock[i]=1: owner<=i, burst_cnt<=1, go LOCKED; ptr unchanged.
- LOCKED:
  - Only owner can be granted; other requesters wait even if owner is idle.
  - Owner accepted with lock=1 and burst_cnt<MAX_BURST-1: burst_cnt++.
  - Owner accepted with lock=0, or burst_cnt reaches MAX_BURST-1 on this acceptance: ptr<=owner+1, go ARB. The final access is still performed.
  - Owner drops req_valid while LOCKED: release that cycle, ptr<=owner+1, go ARB. No grant is issued that cycle.
- MAX_BURST=1: lock never entered; req_lock is ignored.
- Reset (synchronous):
  - req_ready=0, rsp_valid=0, ram_wr_en=0 during the reset cycle.
  - After reset: ptr=0, state ARB, burst_cnt=0.
  - An in-flight read response is dropped: rsp_valid=0 the cycle after reset, even if a read was accepted just before reset.
- Collision: a read and a write to the same address cannot both occur on this port. A collision with the other RAM port follows RAM semantics (old data returned); this block adds no ordering.
- rsp_data is don't-care when rsp_valid=0. The bench must check it only under rsp_valid.

Test Plan:
- Reset, then all req_valid=0 -> req_ready=0, ram_wr_en=0, rsp_valid=0 for 10 cycles.
- Req1 writes addr 0x005 data 0x123456789; next cycle req1 reads 0x005 -> rsp_valid=4'b0010 one cycle after read accept, rsp_data=0x123456789.
- All four valid with reads, lock=0, held 8 cycles -> grant order 0,1,2,3,0,1,2,3; one rsp_valid per cycle, lagging grant by 1 cycle.
- Req2 lock=1 for 12 reads, MAX_BURST=8, req0/req3 also valid -> req2 granted 8 consecutive cycles, then req3, then req0, then req2 resumes.
- Req0 locked, drops valid after 3 accesses while req1 valid -> one idle cycle, then req1 granted; ptr=1.
- Read accepted on cycle where rst asserts on next edge -> rsp_valid stays 0; after release, first grant goes to lowest valid index ≥0.
